bcd_excess3_seq: RTL

Multi-digit BCD-to-Excess-3 conversion sequencer. It accepts a packed word of DIGITS BCD digits over a valid/ready handshake and time-multiplexes one internal `BCD_to_Excess3` instance across the digits, one digit per clock, least significant digit first. It assembles the packed Excess-3 result and presents it on a valid/ready output port. It sits between a BCD producer, such as a counter or display front end, and any consumer of Excess-3 code, so that wide words never need DIGITS parallel converters.

---
 rtl/bcd_excess3_seq.sv | 70 +++++++
 1 files changed

// File: rtl/bcd_excess3_seq.sv
// bcd_excess3_seq: converts a packed BCD word to Excess-3 one digit per clock through a single shared converter.
// Define BCD_SEQ_ERR_CHECK_EN to flag input digits greater than 9 on out_err.
module BCD_to_Excess3 (
  input  logic [3:0] bcd,
  output logic [3:0] xs3
);
  assign xs3 = bcd + 4'd3;
endmodule

module bcd_excess3_seq #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] in_bcd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_xs3,
  output logic                out_err,
  output logic                busy
);
  localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t              state;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] hold;
  logic [3:0]          digit;
  logic [3:0]          xs3;
  assign digit     = hold[4*cnt +: 4];
  assign in_ready  = state == IDLE;
  assign busy      = state != IDLE;
  assign out_valid = state == DONE;
  BCD_to_Excess3 u_conv (.bcd(digit), .xs3(xs3));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      hold    <= '0;
      out_xs3 <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          hold  <= in_bcd;
          cnt   <= '0;
          state <= CONV;
        end
        CONV: begin
          out_xs3[4*cnt +: 4] <= xs3;
          cnt                 <= cnt + 1'b1;
          if (cnt == CW'(DIGITS - 1)) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef BCD_SEQ_ERR_CHECK_EN
  logic err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (state == IDLE && in_valid) err <= 1'b0;
    else if (state == CONV && digit > 4'd9) err <= 1'b1;
  end
  assign out_err = out_valid & err;
`else
  assign out_err = 1'b0;
`endif
endmodule
